// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad scanner and the downstream keymap logic:
// scanner state encoding, default code width and the default raw-index to
// key-value table for a 4x4 pad.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Raw key code width for the default 4x4 matrix.
  localparam int KEY_CODE_W = 4;

  // Tick counters are 8 bits and saturate.
  localparam int TICK_CNT_W = 8;

  // Default keymap: raw index (row*4 + col) -> ASCII legend.
  localparam logic [7:0] KEYMAP [16] = '{
    "1", "2", "3", "A",
    "4", "5", "6", "B",
    "7", "8", "9", "C",
    "*", "0", "#", "D"
  };

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen
// Free-running divider producing a one-cycle tick every 2^DIV_W clocks.
// Ports:
//   CLK    in   system clock
//   RESET  in   asynchronous active-low reset (divider returns to 0)
//   tick   out  one-CLK pulse on the cycle the divider wraps
module keypad_tick_gen #(
  parameter int DIV_W = 15
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // All ones means the next edge wraps the divider.
  assign tick = &div_cnt;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Matrix keypad scanner with press/release debounce, optional auto-repeat
// and a valid/ready event output.
// Ports:
//   CLK         in   system clock
//   RESET       in   asynchronous active-low reset
//   COLUMN      in   column sense, active-low
//   ROW         out  row strobe, one-hot active-low
//   KEY_CODE    out  raw key index row*NCOL + col
//   KEY_REPEAT  out  1 = auto-repeat event, 0 = initial press
//   KEY_VALID   out  event pending
//   KEY_READY   in   consumer takes the event when KEY_VALID & KEY_READY
//   KEY_HELD    out  a debounced key is down
//   OVERRUN     out  sticky: an event was dropped under backpressure
//
// state    | meaning
// SCAN     | walking the matrix one position per tick, looking for a closure
// DEBOUNCE | closure seen, counting consecutive low samples
// HELD     | press accepted, counting toward the next auto-repeat
// RELEASE  | column went high, counting consecutive high samples
//
// COLUMN passes through a two-flop synchronizer; with DIV_W >= 2 it still
// settles well inside the one-tick window between setting a position and
// sampling it.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROW         = 4,
  parameter int NCOL         = 4,
  parameter int DIV_W        = 15,
  parameter int DEBOUNCE_N   = 13,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NCOL-1:0]                 COLUMN,
  output logic [NROW-1:0]                 ROW,
  output logic [$clog2(NROW*NCOL)-1:0]    KEY_CODE,
  output logic                            KEY_REPEAT,
  output logic                            KEY_VALID,
  input  logic                            KEY_READY,
  output logic                            KEY_HELD,
  output logic                            OVERRUN
);

  localparam int ROW_W  = $clog2(NROW);
  localparam int COL_W  = $clog2(NCOL);
  localparam int CODE_W = $clog2(NROW*NCOL);

  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(NROW - 1);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(NCOL - 1);
  localparam logic [TICK_CNT_W-1:0] DEB_N    = TICK_CNT_W'(DEBOUNCE_N);
  localparam logic [TICK_CNT_W-1:0] REP_DLY  = TICK_CNT_W'(REPEAT_DELAY);
  localparam logic [TICK_CNT_W-1:0] REP_RATE = TICK_CNT_W'(REPEAT_RATE);
  localparam logic [TICK_CNT_W-1:0] CNT_MAX  = '1;

  logic                  tick;
  logic [NCOL-1:0]       col_meta, col_sync;
  kp_state_t             state;
  logic [TICK_CNT_W-1:0] cnt, cnt_inc, rep_target;
  logic                  rep_first;
  logic [ROW_W-1:0]      row_cnt, row_adv;
  logic [COL_W-1:0]      col_cnt, col_adv;
  logic                  key_low;
  logic [CODE_W-1:0]     pos_code, ev_code;
  logic                  ev_pulse, ev_repeat;

  function automatic logic [NROW-1:0] row_strobe(input logic [ROW_W-1:0] r);
    logic [NROW-1:0] one_hot;
    one_hot    = '0;
    one_hot[r] = 1'b1;
    return ~one_hot;
  endfunction

  keypad_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= COLUMN;
      col_sync <= col_meta;
    end
  end

  assign key_low    = ~col_sync[col_cnt];
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + TICK_CNT_W'(1);
  assign rep_target = rep_first ? REP_DLY : REP_RATE;
  assign pos_code   = CODE_W'(int'(row_cnt) * NCOL + int'(col_cnt));

  // Next scan position: column first, carry into row.
  always_comb begin
    col_adv = col_cnt + COL_W'(1);
    row_adv = row_cnt;
    if (col_cnt == COL_LAST) begin
      col_adv = '0;
      row_adv = (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= SCAN;
      cnt       <= '0;
      rep_first <= 1'b1;
      row_cnt   <= '0;
      col_cnt   <= '0;
      ROW       <= row_strobe('0);
      KEY_HELD  <= 1'b0;
      ev_pulse  <= 1'b0;
      ev_repeat <= 1'b0;
      ev_code   <= '0;
    end else begin
      ev_pulse <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (key_low && DEB_N <= TICK_CNT_W'(1)) begin
              state     <= HELD;
              KEY_HELD  <= 1'b1;
              cnt       <= '0;
              rep_first <= 1'b1;
              ev_pulse  <= 1'b1;
              ev_repeat <= 1'b0;
              ev_code   <= pos_code;
            end else if (key_low) begin
              state <= DEBOUNCE;
              cnt   <= TICK_CNT_W'(1);
            end else begin
              row_cnt <= row_adv;
              col_cnt <= col_adv;
              ROW     <= row_strobe(row_adv);
            end
          end
          DEBOUNCE: begin
            if (key_low && cnt_inc >= DEB_N) begin
              state     <= HELD;
              KEY_HELD  <= 1'b1;
              cnt       <= '0;
              rep_first <= 1'b1;
              ev_pulse  <= 1'b1;
              ev_repeat <= 1'b0;
              ev_code   <= pos_code;
            end else if (key_low) begin
              cnt <= cnt_inc;
            end else begin
              state   <= SCAN;
              cnt     <= '0;
              row_cnt <= row_adv;
              col_cnt <= col_adv;
              ROW     <= row_strobe(row_adv);
            end
          end
          HELD: begin
            if (key_low) begin
              if (REPEAT_EN != 0 && cnt_inc == rep_target) begin
                cnt       <= '0;
                rep_first <= 1'b0;
                ev_pulse  <= 1'b1;
                ev_repeat <= 1'b1;
                ev_code   <= pos_code;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (DEB_N <= TICK_CNT_W'(1)) begin
              // Single-sample release: no RELEASE dwell needed.
              state    <= SCAN;
              KEY_HELD <= 1'b0;
              cnt      <= '0;
              row_cnt  <= row_adv;
              col_cnt  <= col_adv;
              ROW      <= row_strobe(row_adv);
            end else begin
              state <= RELEASE;
              cnt   <= TICK_CNT_W'(1);
            end
          end
          RELEASE: begin
            if (!key_low && cnt_inc >= DEB_N) begin
              state    <= SCAN;
              KEY_HELD <= 1'b0;
              cnt      <= '0;
              row_cnt  <= row_adv;
              col_cnt  <= col_adv;
              ROW      <= row_strobe(row_adv);
            end else if (!key_low) begin
              cnt <= cnt_inc;
            end else begin
              // Release bounce: resume holding on the repeat-rate cadence.
              state     <= HELD;
              cnt       <= '0;
              rep_first <= 1'b0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  // Output handshake runs every clock; a new event wins over a same-cycle
  // acceptance, and is dropped only when the old one is still unaccepted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      KEY_VALID  <= 1'b0;
      KEY_CODE   <= '0;
      KEY_REPEAT <= 1'b0;
      OVERRUN    <= 1'b0;
    end else if (ev_pulse) begin
      if (KEY_VALID && !KEY_READY) begin
        OVERRUN <= 1'b1;
      end else begin
        KEY_VALID  <= 1'b1;
        KEY_CODE   <= ev_code;
        KEY_REPEAT <= ev_repeat;
      end
    end else if (KEY_VALID && KEY_READY) begin
      KEY_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Two scanners (auto-repeat on and off) share one simulated 4x4 keypad.
// A tick-level reference model predicts position, held flag and events for
// both, and every output is compared on each falling clock edge.
module tb_keypad_scanner;

  localparam int DEB   = 3;
  localparam int RDLY  = 6;
  localparam int RRATE = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        KEY_READY = 1'b1;
  logic [15:0] key_vec = '0;

  logic [3:0] col_a, col_b, row_a, row_b, code_a, code_b;
  logic       rep_a, rep_b, valid_a, valid_b, held_a, held_b, ovr_a, ovr_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  function automatic logic [3:0] col_drive(input logic [3:0] row, input logic [15:0] kv);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (row[r] == 1'b0 && kv[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  assign col_a = col_drive(row_a, key_vec);
  assign col_b = col_drive(row_b, key_vec);

  keypad_scanner #(.NROW(4), .NCOL(4), .DIV_W(2), .DEBOUNCE_N(DEB), .REPEAT_EN(1),
                   .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut (
    .CLK(CLK), .RESET(RESET), .COLUMN(col_a), .ROW(row_a), .KEY_CODE(code_a),
    .KEY_REPEAT(rep_a), .KEY_VALID(valid_a), .KEY_READY(KEY_READY),
    .KEY_HELD(held_a), .OVERRUN(ovr_a));

  keypad_scanner #(.NROW(4), .NCOL(4), .DIV_W(2), .DEBOUNCE_N(DEB), .REPEAT_EN(0),
                   .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut_nr (
    .CLK(CLK), .RESET(RESET), .COLUMN(col_b), .ROW(row_b), .KEY_CODE(code_b),
    .KEY_REPEAT(rep_b), .KEY_VALID(valid_b), .KEY_READY(KEY_READY),
    .KEY_HELD(held_b), .OVERRUN(ovr_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scanner seen as: a scan index that walks 0..15 one step per tick until it
  // locks onto a closed key; while locked, run lengths of low/high samples
  // decide press, release and repeat timing.
  int ecnt = 0;
  int m_pos = 0;
  bit m_locked = 0, m_held = 0, m_first = 1;
  int m_low = 0, m_high = 0, m_since = 0;
  bit evp [2] = '{0, 0};
  int evc = 0;
  bit evr = 0;
  bit hv [2] = '{0, 0};
  int hc [2] = '{0, 0};
  bit hr [2] = '{0, 0};
  bit ho [2] = '{0, 0};

  task automatic model_press();
    m_held  = 1; m_first = 1; m_since = 0; m_high = 0;
    evp[0] = 1; evp[1] = 1; evc = m_pos; evr = 0;
  endtask

  task automatic model_tick();
    bit closed;
    closed = key_vec[m_pos];
    if (!m_locked) begin
      if (closed) begin
        m_locked = 1; m_low = 1; m_high = 0;
        if (m_low >= DEB) model_press();
      end else begin
        m_pos = (m_pos + 1) % 16;
      end
    end else if (closed) begin
      if (!m_held) begin
        m_low++;
        if (m_low >= DEB) model_press();
      end else if (m_high > 0) begin
        m_high = 0; m_since = 0; m_first = 0;
      end else begin
        m_since++;
        if (m_since == (m_first ? RDLY : RRATE)) begin
          evp[0] = 1; evc = m_pos; evr = 1;
          m_since = 0; m_first = 0;
        end
      end
    end else begin
      if (!m_held) begin
        m_locked = 0; m_pos = (m_pos + 1) % 16;
      end else begin
        m_high++;
        if (m_high >= DEB) begin
          m_held = 0; m_locked = 0; m_high = 0; m_pos = (m_pos + 1) % 16;
        end
      end
    end
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ecnt = 0; m_pos = 0; m_locked = 0; m_held = 0; m_first = 1;
      m_low = 0; m_high = 0; m_since = 0; evc = 0; evr = 0;
      for (int i = 0; i < 2; i++) begin
        evp[i] = 0; hv[i] = 0; hc[i] = 0; hr[i] = 0; ho[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (evp[i]) begin
          if (hv[i] && !KEY_READY) ho[i] = 1;
          else begin hv[i] = 1; hc[i] = evc; hr[i] = (i == 0) ? evr : 1'b0; end
        end else if (hv[i] && KEY_READY) begin
          hv[i] = 0;
        end
        evp[i] = 0;
      end
      ecnt++;
      if (ecnt % 4 == 0) model_tick();
    end
  end

  always @(negedge CLK) begin
    logic [3:0] er;
    er = 4'hF;
    er[m_pos / 4] = 1'b0;
    check("row",      row_a,   er);
    check("row_nr",   row_b,   er);
    check("held",     held_a,  m_held);
    check("held_nr",  held_b,  m_held);
    check("valid",    valid_a, hv[0]);
    check("valid_nr", valid_b, hv[1]);
    check("code",     code_a,  hc[0]);
    check("code_nr",  code_b,  hc[1]);
    check("rep",      rep_a,   hr[0]);
    check("rep_nr",   rep_b,   hr[1]);
    check("ovr",      ovr_a,   ho[0]);
    check("ovr_nr",   ovr_b,   ho[1]);
  end

  // ---------------- stimulus ----------------
  // Returns on the falling edge just after the n-th tick from now.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge CLK);
      while (ecnt % 4 != 0) @(negedge CLK);
    end
  endtask

  task automatic wait_scan_at(input int idx);
    int guard = 0;
    while (!(m_pos == idx && !m_locked) && guard < 40) begin
      wait_ticks(1);
      guard++;
    end
    check("reach_pos", guard < 40, 1);
  endtask

  task automatic press_at(input int idx, input int n);
    wait_scan_at(idx);
    key_vec[idx] = 1'b1;
    wait_ticks(n);
    key_vec[idx] = 1'b0;
  endtask

  initial begin
    #1 RESET = 1'b0;
    #1;
    check("rst_row", row_a, 4'hE);
    check("rst_valid", valid_a, 0);
    #18 @(negedge CLK) RESET = 1'b1;

    wait_ticks(20);                 // idle frames
    press_at(9, 20);                // press, delay repeat, rate repeats, release
    wait_ticks(8);
    press_at(9, 2);                 // bounce: no event
    wait_ticks(6);
    press_at(9, 10);                // release bounce back to held
    wait_ticks(1);
    key_vec[9] = 1'b1;
    wait_ticks(5);
    key_vec[9] = 1'b0;
    wait_ticks(8);

    for (int s = 0; s < 40; s++) begin
      key_vec = '0;
      case ($urandom_range(0, 3))
        0: ;
        1, 2: key_vec[$urandom_range(0, 15)] = 1'b1;
        default: begin
          key_vec[$urandom_range(0, 15)] = 1'b1;
          key_vec[$urandom_range(0, 15)] = 1'b1;
        end
      endcase
      KEY_READY = ($urandom_range(0, 3) != 0);
      wait_ticks($urandom_range(1, 24));
    end
    key_vec = '0;
    KEY_READY = 1'b1;
    wait_ticks(20);

    // backpressure through two repeats
    KEY_READY = 1'b0;
    press_at(9, 12);
    wait_ticks(4);
    check("bp_code", code_a, 9);
    check("bp_rep", rep_a, 0);
    check("bp_ovr", ovr_a, 1);
    check("bp_valid", valid_a, 1);
    KEY_READY = 1'b1;
    @(negedge CLK);
    check("bp_drain", valid_a, 0);
    check("bp_ovr_sticky", ovr_a, 1);
    wait_ticks(4);

    // reset in the middle of debounce
    wait_scan_at(9);
    key_vec[9] = 1'b1;
    wait_ticks(2);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_row", row_a, 4'hE);
    check("mid_rst_held", held_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_ovr", ovr_a, 0);
    check("mid_rst_code", code_a, 0);
    check("mid_rst_row_nr", row_b, 4'hE);
    @(negedge CLK);
    @(negedge CLK) RESET = 1'b1;
    wait_ticks(30);
    key_vec[9] = 1'b0;
    wait_ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
